// File: rtl/cassette_recorder.sv
// cassette_recorder: decodes the MC-10 FSK cassette output into bytes for a ready/valid sink.
// Define CASREC_SYNC_EMIT_EN to also emit the 0x3C sync byte ahead of each block's data.
module cassette_recorder #(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned THRESH_HZ  = 1800,
   parameter int unsigned MIN_HZ     = 600,
   parameter int unsigned MAX_HZ     = 3600,
   parameter int unsigned LEADER_MIN = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        cas_in,
   input  logic        enable,
   output logic [7:0]  byte_out,
   output logic        byte_valid,
   input  logic        byte_ready,
   output logic        block_end,
   output logic        overflow,
   output logic [15:0] byte_count,
   output logic [1:0]  state
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_LEADER = 2'd1;
   localparam logic [1:0]  S_DATA   = 2'd2;

   localparam logic [16:0] THR_LIM = 17'(CLK_HZ / THRESH_HZ);
   localparam logic [16:0] GAP_LIM = 17'(CLK_HZ / MIN_HZ);
   localparam logic [16:0] GLT_LIM = 17'(CLK_HZ / MAX_HZ);
   localparam logic [7:0]  LDR_MIN = 8'(LEADER_MIN);

   logic [2:0]  sync_q;
   logic        edge_q;
   logic [16:0] per_q, per_d;
   logic        armed_q, armed_d;
   logic        en_q;
   logic [1:0]  state_q, state_d;
   logic [7:0]  win_q, win_d;
   logic [7:0]  lcnt_q, lcnt_d;
   logic [7:0]  shf_q, shf_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic        bend_q, bend_d;
   logic [7:0]  out_q, out_d;
   logic        valid_q, valid_d;
   logic        ovf_q, ovf_d;
   logic [15:0] cnt_q, cnt_d;

   logic       acc_edge, bit_val, bit_ev, gap_ev, push, hs;
   logic [7:0] push_byte;

   // Glitch edges leave the counter running so they merge into the current cycle.
   assign acc_edge = edge_q && (per_q >= GLT_LIM);
   assign bit_val  = (per_q < THR_LIM);
   assign bit_ev   = acc_edge && armed_q;
   assign gap_ev   = (per_q == GAP_LIM) && !acc_edge;
   assign hs       = valid_q && byte_ready;

   always_comb begin
      per_d = (per_q == '1) ? per_q : per_q + 17'd1;
      if (!enable || acc_edge) per_d = '0;
   end

   always_comb begin
      state_d   = state_q;
      armed_d   = armed_q;
      win_d     = win_q;
      lcnt_d    = lcnt_q;
      shf_d     = shf_q;
      bcnt_d    = bcnt_q;
      bend_d    = 1'b0;
      push      = 1'b0;
      push_byte = '0;
      if (!enable) begin
         state_d = S_IDLE;
         armed_d = 1'b0;
         win_d   = '0;
         lcnt_d  = '0;
         bcnt_d  = '0;
      end else begin
         if (acc_edge) armed_d = 1'b1;
         case (state_q)
            S_IDLE: begin
               if (bit_ev) begin
                  state_d = S_LEADER;
                  lcnt_d  = 8'd1;
                  win_d   = {bit_val, 7'd0};
               end
            end
            S_LEADER: begin
               if (bit_ev) begin
                  win_d  = {bit_val, win_q[7:1]};
                  lcnt_d = (lcnt_q == '1) ? lcnt_q : lcnt_q + 8'd1;
                  if (lcnt_d >= LDR_MIN && win_d == 8'h3C) begin
                     state_d = S_DATA;
                     bcnt_d  = '0;
`ifdef CASREC_SYNC_EMIT_EN
                     push      = 1'b1;
                     push_byte = 8'h3C;
`endif
                  end
               end
            end
            S_DATA: begin
               if (bit_ev) begin
                  shf_d  = {bit_val, shf_q[7:1]};
                  bcnt_d = bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) begin
                     push      = 1'b1;
                     push_byte = shf_d;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         // A gap ends any block; a partially assembled byte is simply abandoned.
         if (gap_ev) begin
            bend_d  = (state_q == S_DATA);
            state_d = S_IDLE;
            armed_d = 1'b0;
            win_d   = '0;
            lcnt_d  = '0;
            bcnt_d  = '0;
         end
      end
   end

   always_comb begin
      out_d   = out_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (push) begin
         if (!valid_q || hs) begin
            out_d   = push_byte;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 16'd1;
         end else begin
            ovf_d = 1'b1;
         end
      end else if (hs) begin
         valid_d = 1'b0;
      end
      if (enable != en_q) ovf_d = 1'b0;
      if (enable && !en_q) cnt_d = '0;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync_q  <= '0;
         edge_q  <= 1'b0;
         per_q   <= '0;
         armed_q <= 1'b0;
         en_q    <= 1'b0;
         state_q <= S_IDLE;
         win_q   <= '0;
         lcnt_q  <= '0;
         shf_q   <= '0;
         bcnt_q  <= '0;
         bend_q  <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= {sync_q[1:0], cas_in};
         edge_q  <= sync_q[1] && !sync_q[2];
         per_q   <= per_d;
         armed_q <= armed_d;
         en_q    <= enable;
         state_q <= state_d;
         win_q   <= win_d;
         lcnt_q  <= lcnt_d;
         shf_q   <= shf_d;
         bcnt_q  <= bcnt_d;
         bend_q  <= bend_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign byte_out   = out_q;
   assign byte_valid = valid_q;
   assign block_end  = bend_q;
   assign overflow   = ovf_q;
   assign byte_count = cnt_q;
   assign state      = state_q;

endmodule

// File: tb/tb_cassette_recorder.sv
// Randomized bench for cassette_recorder against a bit-stream level decoding model.
// Runs at a scaled-down clock so that FSK periods stay a few dozen cycles long.
module tb_cassette_recorder;

   localparam int unsigned CLK_HZ = 90000;
   localparam int THR  = CLK_HZ / 1800;
   localparam int GLT  = CLK_HZ / 3600;
   localparam int LMIN = 16;
`ifdef CASREC_SYNC_EMIT_EN
   localparam bit EMIT = 1'b1;
`else
   localparam bit EMIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, cas_in, enable, byte_ready;
   logic [7:0]  byte_out;
   logic        byte_valid, block_end, overflow;
   logic [15:0] byte_count;
   logic [1:0]  state;

   cassette_recorder #(.CLK_HZ(CLK_HZ)) dut (
      .clk_sys(clk), .reset(reset), .cas_in(cas_in), .enable(enable),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .block_end(block_end), .overflow(overflow), .byte_count(byte_count), .state(state)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int ready_mode;
   int be_cnt = 0;
   logic [7:0] got_q[$];
   int per_q[$];
   bit gl_q[$];
   logic [7:0] exp_q[$];
   int exp_be;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (byte_valid && byte_ready) got_q.push_back(byte_out);
      if (block_end) be_cnt++;
   end

   initial begin
      byte_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'($urandom_range(0, 1));
            default: byte_ready = 1'b1;
         endcase
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic add_per(input int p, input bit gl);
      per_q.push_back(p);
      gl_q.push_back(gl);
   endtask

   task automatic add_bit(input bit b);
      add_per(b ? int'($urandom_range(30, 45)) : int'($urandom_range(55, 90)), 1'b0);
   endtask

   task automatic add_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) add_bit(v[i]);
   endtask

   task automatic add_leader(input int n);
      for (int i = 0; i < n; i++) add_bit(i % 2 == 0);
   endtask

   task automatic clear_stim();
      per_q.delete();
      gl_q.delete();
   endtask

   // Classify each period, hunt the sync byte in the sliding window, then slice bytes.
   task automatic model();
      bit bits[$];
      int sync_at;
      exp_q.delete();
      sync_at = -1;
      foreach (per_q[k]) bits.push_back(per_q[k] < THR);
      for (int i = 7; i < bits.size(); i++) begin
         logic [7:0] w;
         for (int j = 0; j < 8; j++) w[j] = bits[i - 7 + j];
         if (i + 1 >= LMIN && w == 8'h3C) begin
            sync_at = i;
            break;
         end
      end
      exp_be = (sync_at >= 0) ? 1 : 0;
      if (sync_at >= 0) begin
         if (EMIT) exp_q.push_back(8'h3C);
         for (int b = 0; b < (bits.size() - 1 - sync_at) / 8; b++) begin
            logic [7:0] v;
            for (int j = 0; j < 8; j++) v[j] = bits[sync_at + 1 + b * 8 + j];
            exp_q.push_back(v);
         end
      end
   endtask

   task automatic play(input bit tail);
      for (int k = 0; k < per_q.size(); k++) begin
         int p;
         p = per_q[k];
         if (gl_q[k]) begin
            cas_in = 1'b1; wait_clk(5);
            cas_in = 1'b0; wait_clk(3);
            cas_in = 1'b1; wait_clk(p / 2 - 8);
         end else begin
            cas_in = 1'b1; wait_clk(p / 2);
         end
         cas_in = 1'b0; wait_clk(p - p / 2);
      end
      if (tail) begin
         cas_in = 1'b1; wait_clk(20);
         cas_in = 1'b0; wait_clk(250);
      end
   endtask

   task automatic run_and_check(input string tag);
      int hb, bb;
      model();
      hb = got_q.size();
      bb = be_cnt;
      play(1'b1);
      @(negedge clk);
      check({tag, "_nbytes"}, got_q.size() - hb, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (hb + i < got_q.size()) check({tag, "_byte"}, got_q[hb + i], exp_q[i]);
      check({tag, "_block_end"}, be_cnt - bb, exp_be);
      check({tag, "_count"}, byte_count, exp_q.size());
      check({tag, "_state"}, state, 0);
      check({tag, "_overflow"}, overflow, 0);
      clear_stim();
   endtask

   task automatic rearm();
      enable = 1'b0;
      wait_clk(1);
      @(negedge clk);
      check("dis_state", state, 0);
      check("dis_block_end", block_end, 0);
      wait_clk(1);
      enable = 1'b1;
      wait_clk(1);
      @(negedge clk);
      check("rise_count", byte_count, 0);
      check("rise_overflow", overflow, 0);
      wait_clk(50);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_byte_out"}, byte_out, 0);
      check({tag, "_valid"}, byte_valid, 0);
      check({tag, "_block_end"}, block_end, 0);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_count"}, byte_count, 0);
      check({tag, "_state"}, state, 0);
   endtask

   initial begin
      int hb;
      reset = 1'b1; enable = 1'b0; cas_in = 1'b0; ready_mode = 2;
      wait_clk(4);
      @(negedge clk);
      check_reset_vals("rst");
      wait_clk(1);
      reset = 1'b0;
      wait_clk(2);
      enable = 1'b1;
      wait_clk(50);

      for (int it = 0; it < 3; it++) begin
         ready_mode = 1;
         add_leader(int'($urandom_range(20, 28)));
         add_byte(8'h3C);
         if (it == 0) begin
            add_byte(8'h12);
            add_byte(8'hA5);
         end else begin
            for (int b = 0; b < int'($urandom_range(2, 3)); b++) add_byte(8'($urandom));
         end
         run_and_check("main");
         rearm();
      end

      ready_mode = 2;
      add_leader(24);
      add_byte(8'h3C);
      for (int i = 0; i < 8; i++) add_per((i == 0) ? THR - 1 : THR + 1, 1'b0);
      for (int i = 0; i < 8; i++) add_per((i == 0) ? THR + 1 : THR - 1, 1'b0);
      run_and_check("thresh");
      rearm();

      ready_mode = 1;
      add_leader(22);
      add_byte(8'h3C);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] v;
         v = 8'h5A;
         if (v[i]) add_bit(1'b1);
         else add_per(int'($urandom_range(55, 90)), 1'b1);
      end
      run_and_check("glitch");
      rearm();

      ready_mode = 0;
      add_leader(20);
      add_byte(8'h3C);
      add_byte(8'h12);
      add_byte(8'h34);
      model();
      play(1'b1);
      @(negedge clk);
      check("bp_valid", byte_valid, 1);
      check("bp_held", byte_out, exp_q[0]);
      check("bp_overflow", overflow, (exp_q.size() > 1) ? 1 : 0);
      check("bp_count", byte_count, 1);
      clear_stim();
      ready_mode = 2;
      hb = got_q.size();
      wait_clk(3);
      @(negedge clk);
      check("bp_release_hs", got_q.size() - hb, 1);
      check("bp_release_valid", byte_valid, 0);
      rearm();

      ready_mode = 2;
      add_leader(26);
      add_byte(8'h3C);
      for (int i = 0; i < 5; i++) add_bit(1'($urandom_range(0, 1)));
      run_and_check("gap5");
      rearm();

      ready_mode = 0;
      add_leader(20);
      add_byte(8'h3C);
      add_byte(8'h77);
      for (int i = 0; i < 3; i++) add_bit(1'($urandom_range(0, 1)));
      play(1'b0);
      @(negedge clk);
      check("pre_rst_valid", byte_valid, 1);
      check("pre_rst_state", state, 2);
      clear_stim();
      wait_clk(1);
      reset = 1'b1;
      cas_in = 1'b0;
      wait_clk(1);
      @(negedge clk);
      check_reset_vals("mid_rst");
      wait_clk(1);
      reset = 1'b0;
      wait_clk(50);
      ready_mode = 1;
      add_leader(24);
      add_byte(8'h3C);
      add_byte(8'($urandom));
      add_byte(8'($urandom));
      run_and_check("restart");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
